// File: rtl/line_err_calc_if.sv
// line_err_calc_if: sweep control, A2D start/complete handshake and steering-error outputs.
interface line_err_calc_if;
  logic        en;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        IR_en;
  logic [15:0] error;
  logic        err_vld;
  logic        line_present;
  logic        cnv_err;
  modport master (
    input  en, cnv_cmplt, res,
    output strt_cnv, chnnl, IR_en, error, err_vld, line_present, cnv_err
  );
  modport slave (
    output en, cnv_cmplt, res,
    input  strt_cnv, chnnl, IR_en, error, err_vld, line_present, cnv_err
  );
endinterface

// File: rtl/line_err_calc.sv
// line_err_calc: sequences 8 IR sensor conversions per sweep and forms the signed weighted line error.
// Optional macro CNV_TIMEOUT_EN adds a 255-clk conversion timeout with sticky cnv_err.
module line_err_calc #(
  parameter bit          FAST_SIM   = 1'b0,
  parameter logic [11:0] LINE_THRES = 12'h200
) (
  input logic             clk,
  input logic             rst,
  line_err_calc_if.master bus_io
);
  typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT_CMP, DONE, GAP} state_t;
  localparam logic [12:0] SETTLE_LAST = FAST_SIM ? 13'd31 : 13'd1023;
  localparam logic [12:0] GAP_LAST    = FAST_SIM ? 13'd63 : 13'd4095;
  state_t             state_q, state_d;
  logic [12:0]        timer_q, timer_d;
  logic [2:0]         chnnl_q, chnnl_d;
  logic signed [16:0] acc_q, acc_d, acc_sum;
  logic               hit_q, hit_d, hit_now, lp_q, lp_d;
  logic [15:0]        error_q, error_d, error_sat;
  logic [1:0]         sh;
  logic [16:0]        mag;
`ifdef CNV_TIMEOUT_EN
  logic               cerr_q, cerr_d;
`endif
  // Weights are +/-2^k: ch0/ch7 shift 3, ch3/ch4 shift 0, lower half negated.
  assign sh        = chnnl_q[2] ? chnnl_q[1:0] : ~chnnl_q[1:0];
  assign mag       = {5'd0, bus_io.res} << sh;
  assign acc_sum   = acc_q + (chnnl_q[2] ? $signed(mag) : -$signed(mag));
  assign hit_now   = hit_q | (bus_io.res > LINE_THRES);
  assign error_sat = (acc_sum[16] != acc_sum[15]) ? (acc_sum[16] ? 16'h8000 : 16'h7FFF) : acc_sum[15:0];
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 13'd1;
    chnnl_d = chnnl_q;
    acc_d   = acc_q;
    hit_d   = hit_q;
    error_d = error_q;
    lp_d    = lp_q;
`ifdef CNV_TIMEOUT_EN
    cerr_d  = cerr_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = 13'd0;
        state_d = bus_io.en ? SETTLE : IDLE;
      end
      SETTLE: if (timer_q == SETTLE_LAST) begin
        state_d = CONV;
        chnnl_d = 3'd0;
        acc_d   = '0;
        hit_d   = 1'b0;
      end
      CONV: begin
        state_d = WAIT_CMP;
        timer_d = 13'd0;
      end
      WAIT_CMP: if (bus_io.cnv_cmplt) begin
        acc_d   = acc_sum;
        hit_d   = hit_now;
        chnnl_d = chnnl_q + 3'd1;
        state_d = (chnnl_q == 3'd7) ? DONE : CONV;
        // Results are registered on entry to DONE so err_vld and error line up.
        if (chnnl_q == 3'd7) begin
          lp_d    = hit_now;
          error_d = hit_now ? error_sat : error_q;
        end
      end
`ifdef CNV_TIMEOUT_EN
      else if (timer_q == 13'd254) begin
        cerr_d  = 1'b1;
        state_d = GAP;
        timer_d = 13'd0;
      end
`endif
      DONE: begin
        state_d = GAP;
        timer_d = 13'd0;
      end
      GAP: if (timer_q == GAP_LAST) begin
        state_d = SETTLE;
        timer_d = 13'd0;
      end
      default: state_d = IDLE;
    endcase
    if (!bus_io.en && state_q != IDLE) begin
      state_d = IDLE;
      timer_d = 13'd0;
      chnnl_d = 3'd0;
      acc_d   = '0;
      hit_d   = 1'b0;
      error_d = error_q;
      lp_d    = lp_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      chnnl_q <= '0;
      acc_q   <= '0;
      hit_q   <= 1'b0;
      error_q <= '0;
      lp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      chnnl_q <= chnnl_d;
      acc_q   <= acc_d;
      hit_q   <= hit_d;
      error_q <= error_d;
      lp_q    <= lp_d;
    end
  end
`ifdef CNV_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cerr_q <= 1'b0;
    else cerr_q <= cerr_d;
  end
  assign bus_io.cnv_err = cerr_q;
`else
  assign bus_io.cnv_err = 1'b0;
`endif
  assign bus_io.strt_cnv     = state_q == CONV;
  assign bus_io.chnnl        = chnnl_q;
  assign bus_io.IR_en        = state_q == SETTLE || state_q == CONV || state_q == WAIT_CMP;
  assign bus_io.error        = error_q;
  assign bus_io.err_vld      = state_q == DONE && hit_q;
  assign bus_io.line_present = lp_q;
endmodule

// File: tb/tb_line_err_calc.sv
// tb_line_err_calc: randomized-latency A2D model with a behavioural weighted-sum reference for line_err_calc.
module tb_line_err_calc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  line_err_calc_if bus ();
  line_err_calc #(.FAST_SIM(1'b1)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [11:0] vals [8];
  bit          withhold [8];
  bit          drop_en_on7 = 1'b0;
  int          strt_cnt, cmpl_cnt, vld_cnt, strt_cyc, vld_cyc, last_cmpl_cyc, en_cyc;
  logic [15:0] vld_err;
  int          ch_seq [$];
  logic [15:0] exp_error = 16'h0000;
  bit          exp_lp = 1'b0;
  bit          exp_cerr = 1'b0;
  // A2D model: answers each strt_cnv after 1..5 clks with that channel's value
  initial begin
    bus.cnv_cmplt = 1'b0;
    bus.res = 12'h000;
    forever begin
      @(negedge clk);
      while (bus.strt_cnv === 1'b1) begin
        automatic int ch = int'(bus.chnnl);
        ch_seq.push_back(ch);
        strt_cnt++;
        strt_cyc = cyc;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        if (!withhold[ch]) begin
          bus.res = vals[ch];
          bus.cnv_cmplt = 1'b1;
          cmpl_cnt++;
          if (ch == 7) begin
            last_cmpl_cyc = cyc;
            if (drop_en_on7) bus.en = 1'b0;
          end
          @(negedge clk);
          bus.cnv_cmplt = 1'b0;
          bus.res = 12'($urandom);
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (bus.err_vld === 1'b1) begin
      vld_cnt++;
      vld_cyc = cyc;
      vld_err = bus.error;
    end
  end
  function automatic void ref_sweep(output bit hit, output logic [15:0] err);
    int w [8];
    int s;
    w = '{-8, -4, -2, -1, 1, 2, 4, 8};
    s = 0;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s += w[i] * int'(vals[i]);
      if (vals[i] > 12'h200) hit = 1'b1;
    end
    err = s > 32767 ? 16'h7FFF : s < -32768 ? 16'h8000 : 16'(s);
  endfunction
  task automatic set_vals(input logic [11:0] v0, v1, v2, v3, v4, v5, v6, v7);
    vals = '{v0, v1, v2, v3, v4, v5, v6, v7};
  endtask
  task automatic start_sweep();
    bus.en = 1'b0;
    repeat (10) @(negedge clk);
    ch_seq.delete();
    strt_cnt = 0;
    cmpl_cnt = 0;
    vld_cnt = 0;
    vld_cyc = -1;
    last_cmpl_cyc = -100;
    en_cyc = cyc;
    bus.en = 1'b1;
  endtask
  task automatic wait_strt(input int n, output bit ok);
    int t = 0;
    while (strt_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = strt_cnt >= n;
  endtask
  task automatic wait_cmpl(input int n, output bit ok);
    int t = 0;
    while (cmpl_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = cmpl_cnt >= n;
  endtask
  task automatic run_sweep(input string name);
    bit hit, ok, seq_ok;
    logic [15:0] e;
    ref_sweep(hit, e);
    start_sweep();
    wait_cmpl(8, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s timeout: completions %0d want 8", name, cmpl_cnt); end
    if (hit) exp_error = e;
    exp_lp = hit;
    checks++;
    if (vld_cnt != (hit ? 1 : 0)) begin errors++; $display("FAIL %s err_vld count: got %0d want %0d", name, vld_cnt, hit ? 1 : 0); end
    checks++;
    if (bus.error !== exp_error) begin errors++; $display("FAIL %s error: got %h want %h", name, bus.error, exp_error); end
    checks++;
    if (bus.line_present !== exp_lp) begin errors++; $display("FAIL %s line_present: got %b want %b", name, bus.line_present, exp_lp); end
    checks++;
    if (bus.cnv_err !== exp_cerr) begin errors++; $display("FAIL %s cnv_err: got %b want %b", name, bus.cnv_err, exp_cerr); end
    seq_ok = ch_seq.size() == 8;
    for (int i = 0; i < 8 && seq_ok; i++) seq_ok = ch_seq[i] == i;
    checks++;
    if (!seq_ok) begin errors++; $display("FAIL %s channel order: got %p want 0..7", name, ch_seq); end
    if (hit) begin
      checks++;
      if (vld_cyc != last_cmpl_cyc + 1 || vld_err !== e) begin
        errors++;
        $display("FAIL %s err_vld timing: got cyc %0d err %h want cyc %0d err %h", name, vld_cyc, vld_err, last_cmpl_cyc + 1, e);
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.strt_cnv, bus.chnnl, bus.IR_en, bus.error, bus.err_vld, bus.line_present, bus.cnv_err} !== 24'h0) begin
      errors++;
      $display("FAIL reset outputs: got %h want 000000", {bus.strt_cnv, bus.chnnl, bus.IR_en, bus.error, bus.err_vld, bus.line_present, bus.cnv_err});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (bus.IR_en !== 1'b0 || strt_cnt != 0) begin errors++; $display("FAIL idle with en low: got IR_en %b strt %0d want 0 0", bus.IR_en, strt_cnt); end
  endtask
  task automatic test_no_line();
    set_vals(12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100);
    run_sweep("no_line");
  endtask
  task automatic test_right_edge_gap();
    bit ok;
    set_vals(0, 0, 0, 0, 0, 0, 0, 12'hFFF);
    run_sweep("right_edge");
    wait_strt(9, ok);
    checks++;
    if (!ok || strt_cyc - vld_cyc != 97) begin errors++; $display("FAIL gap+settle: got %0d clks want 97", ok ? strt_cyc - vld_cyc : -1); end
  endtask
  task automatic test_balanced();
    set_vals(12'hFFF, 0, 0, 0, 0, 0, 0, 12'hFFF);
    run_sweep("balanced");
  endtask
  task automatic test_saturation();
    set_vals(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 0, 0, 0);
    run_sweep("sat_neg");
    set_vals(0, 0, 0, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    run_sweep("sat_pos");
  endtask
  task automatic test_threshold();
    set_vals(0, 0, 0, 12'h200, 0, 0, 0, 0);
    run_sweep("thres_equal");
    set_vals(0, 0, 0, 12'h201, 0, 0, 0, 0);
    run_sweep("thres_above");
  endtask
  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++)
        vals[i] = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 12'h200));
      run_sweep($sformatf("random%0d", k));
    end
  endtask
  task automatic test_abort();
    bit ok;
    set_vals(12'h300, 12'h300, 12'h300, 12'h300, 0, 0, 0, 0);
    withhold[3] = 1'b1;
    start_sweep();
    wait_strt(4, ok);
    repeat (5) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || bus.IR_en !== 1'b0) begin errors++; $display("FAIL abort IR_en: got %b want 0", bus.IR_en); end
    repeat (40) @(negedge clk);
    checks++;
    if (strt_cnt != 4 || vld_cnt != 0 || bus.error !== exp_error || bus.line_present !== exp_lp) begin
      errors++;
      $display("FAIL abort idle: got strt %0d vld %0d err %h lp %b want 4 0 %h %b", strt_cnt, vld_cnt, bus.error, bus.line_present, exp_error, exp_lp);
    end
    withhold[3] = 1'b0;
    ch_seq.delete();
    en_cyc = cyc;
    bus.en = 1'b1;
    wait_strt(5, ok);
    checks++;
    if (!ok || strt_cyc - en_cyc != 33 || ch_seq[0] != 0) begin
      errors++;
      $display("FAIL restart: got %0d clks ch %0d want 33 ch 0", strt_cyc - en_cyc, ch_seq.size() > 0 ? ch_seq[0] : -1);
    end
  endtask
  task automatic test_abort_on_last();
    bit ok;
    set_vals(0, 0, 0, 0, 0, 12'h800, 0, 0);
    start_sweep();
    drop_en_on7 = 1'b1;
    wait_cmpl(8, ok);
    repeat (5) @(negedge clk);
    drop_en_on7 = 1'b0;
    checks++;
    if (!ok || vld_cnt != 0 || bus.error !== exp_error || bus.line_present !== exp_lp || bus.IR_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_on_last: got vld %0d err %h lp %b want 0 %h %b", vld_cnt, bus.error, bus.line_present, exp_error, exp_lp);
    end
  endtask
  task automatic test_async_reset();
    bit ok;
    set_vals(0, 0, 0, 0, 0, 0, 12'hFFF, 0);
    start_sweep();
    wait_strt(3, ok);
    @(negedge clk);
    #2 rst = 1'b1;
    bus.en = 1'b0;
    #1;
    checks++;
    if (!ok || {bus.strt_cnv, bus.chnnl, bus.IR_en, bus.error, bus.err_vld, bus.line_present, bus.cnv_err} !== 24'h0) begin
      errors++;
      $display("FAIL async reset: got IR_en %b chnnl %0d err %h want 0 0 0000", bus.IR_en, bus.chnnl, bus.error);
    end
    exp_error = 16'h0000;
    exp_lp = 1'b0;
    exp_cerr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
`ifdef CNV_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int t = 0;
    set_vals(0, 0, 12'hFFF, 0, 0, 0, 0, 0);
    withhold[2] = 1'b1;
    start_sweep();
    wait_strt(3, ok);
    while (bus.cnv_err !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!ok || cyc - strt_cyc != 256) begin errors++; $display("FAIL timeout latency: got %0d clks want 256", cyc - strt_cyc); end
    checks++;
    if (vld_cnt != 0 || bus.error !== exp_error || bus.line_present !== exp_lp) begin
      errors++;
      $display("FAIL timeout discard: got vld %0d err %h lp %b want 0 %h %b", vld_cnt, bus.error, bus.line_present, exp_error, exp_lp);
    end
    withhold[2] = 1'b0;
    exp_cerr = 1'b1;
    set_vals(0, 0, 0, 0, 0, 0, 12'h300, 0);
    run_sweep("sticky_cnv_err");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cerr = 1'b0;
    exp_error = 16'h0000;
    exp_lp = 1'b0;
    checks++;
    if (bus.cnv_err !== 1'b0) begin errors++; $display("FAIL cnv_err clear: got %b want 0", bus.cnv_err); end
  endtask
`endif
  initial begin
    for (int i = 0; i < 8; i++) begin
      vals[i] = 12'h000;
      withhold[i] = 1'b0;
    end
    strt_cnt = 0;
    cmpl_cnt = 0;
    vld_cnt = 0;
    test_reset();
    test_no_line();
    test_right_edge_gap();
    test_balanced();
    test_saturation();
    test_threshold();
    test_random();
    test_abort();
    test_abort_on_last();
    test_async_reset();
`ifdef CNV_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_err_calc.md
Name: line_err_calc

Overview:
Upstream feeder of the steering PID. Sequences eight IR line-sensor A2D conversions per sweep over a start/complete handshake, then forms the signed weighted steering error. Produces error, err_vld and line_present, which drive the PID directly. Owns IR emitter enable and inter-sweep timing.

Parameters:
FAST_SIM, 0, 1 shortens settle/gap timers for simulation (settle 32, gap 64 clks instead of 1024, 4096)
LINE_THRES, 12'h200, a channel reading strictly greater than this counts as "on line"

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
en  input  1  sweep enable (tied to go); low aborts and idles
strt_cnv  output  1  one-clock pulse requesting an A2D conversion
chnnl  output  3  channel index for the current conversion, stable from strt_cnv through cnv_cmplt
cnv_cmplt  input  1  one-clock pulse, conversion result valid on res
res  input  12  unsigned conversion result
IR_en  output  1  IR emitter enable
error  output  16  signed weighted error, positive = line to the right
err_vld  output  1  one-clock pulse, error updated
line_present  output  1  at least one channel above LINE_THRES in the last sweep
cnv_err  output  1  sticky conversion-timeout flag (see Optional Feature)

Behaviour:
- Reset values: strt_cnv=0, chnnl=0, IR_en=0, error=16'h0000, err_vld=0, line_present=0, cnv_err=0; FSM in IDLE, accumulator 0, timer 0.
- FSM states: IDLE, SETTLE, CONV, WAIT_CMP, DONE, GAP.
- IDLE: outputs quiescent; when en=1, go to SETTLE next clk with IR_en=1, timer cleared.
- SETTLE: IR_en=1; after 1024 clks (32 if FAST_SIM), go to CONV with chnnl=0 and accumulator cleared.
- CONV: strt_cnv=1 for exactly one clk; go to WAIT_CMP.
- WAIT_CMP: wait for cnv_cmplt. On cnv_cmplt: add weight[chnnl]*res to accumulator; OR (res>LINE_THRES) into hit flag. If chnnl==7 go to DONE, else chnnl+1 and go to CONV. cnv_cmplt outside WAIT_CMP is ignored.
- Weights (signed): ch0 -8, ch1 -4, ch2 -2, ch3 -1, ch4 +1, ch5 +2, ch6 +4, ch7 +8. Multiplies are shifts. Accumulator is 17-bit signed (|max| = 15*4095 = 61425).
- DONE (1 clk): line_present<=hit. If hit=1: error <= acc saturated to 16-bit signed (>32767 gives 16'h7FFF, <-32768 gives 16'h8000), and err_vld pulses this clk. If hit=0: error holds and no err_vld. IR_en=0. Go to GAP.
- Latency: err_vld is high the clock after the final cnv_cmplt.
- GAP: IR_en=0; after 4096 clks (64 if FAST_SIM), go to SETTLE.
- en=0 in any non-IDLE state: next clk go to IDLE. strt_cnv=0, IR_en=0, partial sweep discarded, chnnl=0. error and line_present hold, no err_vld. A later en=1 restarts at SETTLE/ch0.
- Simultaneous en falling with cnv_cmplt on ch7: abort wins, no err_vld.
- Async rst at any time forces reset values immediately.

Optional Feature:
Macro CNV_TIMEOUT_EN.
- Defined: an 8-bit counter runs in WAIT_CMP. If 255 clks elapse without cnv_cmplt, cnv_err sets (sticky until rst), the sweep is discarded (no err_vld, line_present held) and the FSM goes to GAP.
- Undefined: WAIT_CMP waits indefinitely and cnv_err is tied to 0.

Test Plan:
- FAST_SIM=1, en=1, A2D model returns res=12'h100 on all channels -> 8 strt_cnv pulses with chnnl 0..7 in order, then line_present=0, no err_vld, error stays 16'h0000.
- ch7=12'hFFF, others 0 -> err_vld one clk after 8th cnv_cmplt, error=16'h7FF8, line_present=1; next sweep begins after 64-clk gap plus 32-clk settle.
- ch0=ch7=12'hFFF, others 0 -> error=16'h0000, err_vld=1, line_present=1.
- ch0..ch3=12'hFFF, ch4..ch7=0 -> error saturates to 16'h8000; ch4..ch7=12'hFFF, ch0..ch3=0 -> 16'h7FFF.
- en dropped while waiting on ch3 -> IR_en=0 and FSM in IDLE next clk, no err_vld, error unchanged. Re-raise en -> first strt_cnv after 32 clks with chnnl=0.
- CNV_TIMEOUT_EN defined, model withholds cnv_cmplt on ch2 -> cnv_err=1 after 255 clks, no err_vld, cnv_err stays set across later good sweeps until rst.
